regfile_write_arbiter: RTL
==========================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single write port of the 8 x 32-bit register array between two producers (req0 = ALU, req1 = load unit).
//  Performs round-robin arbitration with valid/ready handshakes and registers the winning write onto the array's write port.
//  Keeps a pending-write scoreboard so decode logic can stall reads of registers that still await a result.
// PARAMETERS
//  BITS_DATA  32  width of register data
//  BITS_ADDR  3   register address width (2**BITS_ADDR registers)
// PORTS
//  clk        in   1                 single clock, all state updates on rising edge
//  rst        in   1                 synchronous reset, active-high
//  req0Valid  in   1                 requester 0 has a write pending
//  req0Addr   in   BITS_ADDR         requester 0 destination register
//  req0Data   in   BITS_DATA         requester 0 write data
//  req0Ready  out  1                 requester 0 transfer accepted this cycle when req0Valid=1
//  req1Valid  in   1                 requester 1 has a write pending
//  req1Addr   in   BITS_ADDR         requester 1 destination register
//  req1Data   in   BITS_DATA         requester 1 write data
//  req1Ready  out  1                 requester 1 transfer accepted this cycle when req1Valid=1
//  rsvValid   in   1                 decode reserves a destination register
//  rsvAddr    in   BITS_ADDR         register being reserved
//  rdAddr1    in   BITS_ADDR         read address 1 to be checked for a hazard
//  rdAddr2    in   BITS_ADDR         read address 2 to be checked for a hazard
//  readStall  out  1                 busyMask[rdAddr1] | busyMask[rdAddr2] (combinational)
//  wrEnable   out  1                 write strobe to the register array
//  wrAddr     out  BITS_ADDR         write address to the register array
//  wrData     out  BITS_DATA         write data to the register array
//  busyMask   out  2**BITS_ADDR      scoreboard: bit i = 1 means register i has a write outstanding
//  lastGrant  out  1                 index of the most recently granted requester
// BEHAVIOUR
//  - Reset values (rst=1 at an edge):
//    - wrEnable=0, wrAddr=0, wrData=0, busyMask=0, lastGrant=0.
//    - rrPtr=0, i.e. requester 0 has priority.
//    - reqNReady forced 0 while rst=1.
//  - Arbitration (combinational):
//    - Only one valid: that requester wins.
//    - Both valid: the requester selected by rrPtr wins.
//    - reqNReady = reqNValid & winner==N & !rst.
//    - At most one ready per cycle; ready is never asserted without the matching valid.
//  - Handshake:
//    - A transfer occurs on an edge where valid&ready=1.
//    - A requester holds valid, addr and data stable until it sees ready.
//    - Dropping valid before ready is illegal; behaviour is unspecified.
//  - Pointer update: on a transfer by N, rrPtr <= ~N and lastGrant <= N. With no transfer, both hold.
//  - Write port timing (latency 1):
//    - On a transfer edge: wrEnable<=1, wrAddr<=addr, wrData<=data.
//    - Otherwise wrEnable<=0; wrAddr and wrData hold.
//    - Back-to-back transfers give a continuous wrEnable=1 stream, 1 write/cycle throughput.
//  - Scoreboard, evaluated each edge:
//    - Clear: a transfer clears busyMask[addr], so the clear is visible in the same cycle wrEnable=1.
//    - Set: rsvValid sets busyMask[rsvAddr].
//    - Reserve and clear of the same address on the same edge: set wins (a new producer owns the register).
//    - Reserve of an already-busy register: the bit stays 1; no counting.
//    - A transfer to a non-busy register is legal and leaves the bit 0.
//  - readStall is purely combinational from busyMask; there is no bypass of wrData.
//  - Reset mid-operation:
//    - The in-flight wrEnable pulse is cancelled on the reset edge.
//    - All reservations are lost.
//    - Requesters must re-present after rst deasserts.
// TESTING
//  1. Reset:
//     - rst=1 for 2 cycles with both valids high -> readies 0.
//     - After reset: wrEnable=0, busyMask=8'h00.
//  2. Single requester:
//     - req0Valid=1, addr=3, data=32'hDEADBEEF -> req0Ready=1 that cycle.
//     - Next cycle: wrEnable=1, wrAddr=3, wrData=32'hDEADBEEF.
//  3. Contention:
//     - Both valid for 4 cycles with distinct data.
//     - Required grants: 0,1,0,1; lastGrant toggles; wrEnable high 4 consecutive cycles.
//  4. Scoreboard:
//     - rsvAddr=5 -> busyMask=8'h20; rdAddr1=5 gives readStall=1.
//     - req1 writes reg 5 -> busyMask=8'h00 in the wrEnable cycle.
//  5. Simultaneous reserve and clear:
//     - rsvAddr=2 on the same edge as a transfer to reg 2 -> busyMask[2] stays 1.
//     - wrEnable=1, wrAddr=2 on the next cycle.
//  6. Mid-operation reset:
//     - Assert rst on the edge after a transfer -> wrEnable=0 and busyMask=0 next cycle.
//     - Requester 0 then has priority again.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
//  Module   : regfile_write_arbiter
//  Brief    : Round-robin arbiter sharing the register-array write port
//             between two producers, with a pending-write scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter #(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0Valid,
  input  logic [BITS_ADDR-1:0]      req0Addr,
  input  logic [BITS_DATA-1:0]      req0Data,
  output logic                      req0Ready,
  input  logic                      req1Valid,
  input  logic [BITS_ADDR-1:0]      req1Addr,
  input  logic [BITS_DATA-1:0]      req1Data,
  output logic                      req1Ready,
  input  logic                      rsvValid,
  input  logic [BITS_ADDR-1:0]      rsvAddr,
  input  logic [BITS_ADDR-1:0]      rdAddr1,
  input  logic [BITS_ADDR-1:0]      rdAddr2,
  output logic                      readStall,
  output logic                      wrEnable,
  output logic [BITS_ADDR-1:0]      wrAddr,
  output logic [BITS_DATA-1:0]      wrData,
  output logic [2**BITS_ADDR-1:0]   busyMask,
  output logic                      lastGrant
);

  localparam int c_NUM_REGS = 2**BITS_ADDR;
  localparam logic [c_NUM_REGS-1:0] c_ONE = {{(c_NUM_REGS-1){1'b0}}, 1'b1};

  logic                   r_rrPtr;
  logic                   r_lastGrant;
  logic                   r_wrEnable;
  logic [BITS_ADDR-1:0]   r_wrAddr;
  logic [BITS_DATA-1:0]   r_wrData;
  logic [c_NUM_REGS-1:0]  r_busy;

  logic                   w_grant1;
  logic                   w_xfer;
  logic [BITS_ADDR-1:0]   w_addr;
  logic [BITS_DATA-1:0]   w_data;
  logic [c_NUM_REGS-1:0]  w_clrMask;
  logic [c_NUM_REGS-1:0]  w_setMask;

  // Requester 1 wins when it is alone or when the pointer favours it.
  always_comb begin
    w_grant1  = req1Valid & (~req0Valid | r_rrPtr);
    req0Ready = req0Valid & ~w_grant1 & ~rst;
    req1Ready = req1Valid &  w_grant1 & ~rst;
    w_xfer    = req0Ready | req1Ready;
    w_addr    = w_grant1 ? req1Addr : req0Addr;
    w_data    = w_grant1 ? req1Data : req0Data;
    w_clrMask = w_xfer   ? (c_ONE << w_addr)  : '0;
    w_setMask = rsvValid ? (c_ONE << rsvAddr) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rrPtr     <= 1'b0;
      r_lastGrant <= 1'b0;
      r_wrEnable  <= 1'b0;
      r_wrAddr    <= '0;
      r_wrData    <= '0;
      r_busy      <= '0;
    end else begin
      r_wrEnable <= w_xfer;
      if (w_xfer) begin
        r_rrPtr     <= ~w_grant1;
        r_lastGrant <= w_grant1;
        r_wrAddr    <= w_addr;
        r_wrData    <= w_data;
      end
      // A reservation on the same edge belongs to a newer producer, so set wins.
      r_busy <= (r_busy & ~w_clrMask) | w_setMask;
    end
  end

  assign readStall = r_busy[rdAddr1] | r_busy[rdAddr2];
  assign wrEnable  = r_wrEnable;
  assign wrAddr    = r_wrAddr;
  assign wrData    = r_wrData;
  assign busyMask  = r_busy;
  assign lastGrant = r_lastGrant;

endmodule

`default_nettype wire
